// File: rtl/system_bus_arbiter_pkg.sv
// Shared types and widths for the system bus arbiter.
package system_bus_arbiter_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin winner search: first requester after last_index_i, wrapping.
module rr_priority_select #(
    parameter int NUM_HOST = 2,
    parameter int IDX_W    = $clog2(NUM_HOST)
) (
    input  logic [NUM_HOST-1:0] request_i,
    input  logic [IDX_W-1:0]    last_index_i,
    output logic [NUM_HOST-1:0] winner_onehot_o,
    output logic [IDX_W-1:0]    winner_index_o,
    output logic                winner_valid_o
);

    localparam int unsigned N  = NUM_HOST;
    localparam int unsigned SW = IDX_W + 1;

    logic [SW-1:0] cand;

    always_comb begin
        winner_onehot_o = '0;
        winner_index_o  = '0;
        winner_valid_o  = 1'b0;
        cand            = '0;
        // One extra bit holds last+offset before the modulo wrap.
        for (int unsigned off = 1; off <= N; off++) begin
            cand = {1'b0, last_index_i} + SW'(off);
            if (cand >= SW'(N)) begin
                cand = cand - SW'(N);
            end
            if (!winner_valid_o && request_i[cand[IDX_W-1:0]]) begin
                winner_valid_o                     = 1'b1;
                winner_index_o                     = cand[IDX_W-1:0];
                winner_onehot_o[cand[IDX_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/system_bus_arbiter.sv
// Round-robin arbiter sharing the system bus host port between NUM_HOST masters,
// one transaction in flight, with forced completion after TIMEOUT_CYCLES.
module system_bus_arbiter
    import system_bus_arbiter_pkg::*;
#(
    parameter int NUM_HOST       = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic [NUM_HOST*32-1:0]     host_rw_address_i,
    output logic [NUM_HOST*32-1:0]     host_read_data_o,
    input  logic [NUM_HOST-1:0]        host_read_request_i,
    output logic [NUM_HOST-1:0]        host_read_response_o,
    input  logic [NUM_HOST*32-1:0]     host_write_data_i,
    input  logic [NUM_HOST*4-1:0]      host_write_strobe_i,
    input  logic [NUM_HOST-1:0]        host_write_request_i,
    output logic [NUM_HOST-1:0]        host_write_response_o,
    output logic [31:0]                bus_rw_address_o,
    input  logic [31:0]                bus_read_data_i,
    output logic                       bus_read_request_o,
    input  logic                       bus_read_response_i,
    output logic [31:0]                bus_write_data_o,
    output logic [3:0]                 bus_write_strobe_o,
    output logic                       bus_write_request_o,
    input  logic                       bus_write_response_i,
    output logic [NUM_HOST-1:0]        grant_o,
    output logic                       timeout_o
);

    localparam int IDX_W = $clog2(NUM_HOST);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e          state_q, state_d;
    logic [NUM_HOST-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]    last_idx_q, last_idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_read_q, is_read_d;

    logic [WORD_W-1:0]   addr_a  [NUM_HOST];
    logic [WORD_W-1:0]   wdata_a [NUM_HOST];
    logic [STRB_W-1:0]   strb_a  [NUM_HOST];

    for (genvar h = 0; h < NUM_HOST; h++) begin : g_unpack
        assign addr_a[h]  = host_rw_address_i[h*WORD_W +: WORD_W];
        assign wdata_a[h] = host_write_data_i[h*WORD_W +: WORD_W];
        assign strb_a[h]  = host_write_strobe_i[h*STRB_W +: STRB_W];
    end

    logic [NUM_HOST-1:0] pending;
    logic [NUM_HOST-1:0] win_onehot;
    logic [IDX_W-1:0]    win_idx;
    logic                win_valid;

    assign pending = host_read_request_i | host_write_request_i;

    rr_priority_select #(
        .NUM_HOST (NUM_HOST)
    ) u_select (
        .request_i       (pending),
        .last_index_i    (last_idx_q),
        .winner_onehot_o (win_onehot),
        .winner_index_o  (win_idx),
        .winner_valid_o  (win_valid)
    );

    logic [IDX_W-1:0]  sel_idx;
    logic              zero_rdata;
    logic [WORD_W-1:0] rdata;

    always_comb begin
        state_d               = state_q;
        grant_d               = grant_q;
        grant_idx_d           = grant_idx_q;
        last_idx_d            = last_idx_q;
        cnt_d                 = cnt_q;
        is_read_d             = is_read_q;
        sel_idx               = '0;
        zero_rdata            = 1'b0;
        bus_read_request_o    = 1'b0;
        bus_write_request_o   = 1'b0;
        host_read_response_o  = '0;
        host_write_response_o = '0;
        timeout_o             = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    sel_idx             = win_idx;
                    // Read wins when a master raises both requests.
                    bus_read_request_o  = host_read_request_i[win_idx];
                    bus_write_request_o = host_write_request_i[win_idx] & ~host_read_request_i[win_idx];
                    grant_d             = win_onehot;
                    grant_idx_d         = win_idx;
                    last_idx_d          = win_idx;
                    cnt_d               = '0;
                    is_read_d           = host_read_request_i[win_idx];
                    state_d             = ST_WAIT;
                end
            end
            ST_WAIT: begin
                sel_idx = grant_idx_q;
                if (bus_read_response_i || bus_write_response_i) begin
                    host_read_response_o  = grant_q & {NUM_HOST{bus_read_response_i}};
                    host_write_response_o = grant_q & {NUM_HOST{bus_write_response_i}};
                    grant_d               = '0;
                    state_d               = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    if (is_read_q) begin
                        host_read_response_o = grant_q;
                    end else begin
                        host_write_response_o = grant_q;
                    end
                    zero_rdata = 1'b1;
                    timeout_o  = 1'b1;
                    grant_d    = '0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A reset cycle aborts the transaction without signalling anyone.
        if (reset_i) begin
            bus_read_request_o    = 1'b0;
            bus_write_request_o   = 1'b0;
            host_read_response_o  = '0;
            host_write_response_o = '0;
            timeout_o             = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            last_idx_q  <= IDX_W'(NUM_HOST - 1);
            cnt_q       <= '0;
            is_read_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            last_idx_q  <= last_idx_d;
            cnt_q       <= cnt_d;
            is_read_q   <= is_read_d;
        end
    end

    assign rdata              = zero_rdata ? '0 : bus_read_data_i;
    assign host_read_data_o   = {NUM_HOST{rdata}};
    assign bus_rw_address_o   = addr_a[sel_idx];
    assign bus_write_data_o   = wdata_a[sel_idx];
    assign bus_write_strobe_o = strb_a[sel_idx];
    assign grant_o            = grant_q;

endmodule

// File: tb/tb_system_bus_arbiter.sv
// Scoreboard bench for system_bus_arbiter: master drivers, a bus device model, negedge monitor.
module tb_system_bus_arbiter;

    localparam int NH = 2;
    localparam int TO = 8;

    logic              clock_i = 1'b0;
    logic              reset_i = 1'b1;
    logic [NH*32-1:0]  host_rw_address_i = '0;
    logic [NH*32-1:0]  host_read_data_o;
    logic [NH-1:0]     host_read_request_i = '0;
    logic [NH-1:0]     host_read_response_o;
    logic [NH*32-1:0]  host_write_data_i = '0;
    logic [NH*4-1:0]   host_write_strobe_i = '0;
    logic [NH-1:0]     host_write_request_i = '0;
    logic [NH-1:0]     host_write_response_o;
    logic [31:0]       bus_rw_address_o;
    logic [31:0]       bus_read_data_i = '0;
    logic              bus_read_request_o;
    logic              bus_read_response_i = 1'b0;
    logic [31:0]       bus_write_data_o;
    logic [3:0]        bus_write_strobe_o;
    logic              bus_write_request_o;
    logic              bus_write_response_i = 1'b0;
    logic [NH-1:0]     grant_o;
    logic              timeout_o;

    system_bus_arbiter #(
        .NUM_HOST       (NH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock_i               (clock_i),
        .reset_i               (reset_i),
        .host_rw_address_i     (host_rw_address_i),
        .host_read_data_o      (host_read_data_o),
        .host_read_request_i   (host_read_request_i),
        .host_read_response_o  (host_read_response_o),
        .host_write_data_i     (host_write_data_i),
        .host_write_strobe_i   (host_write_strobe_i),
        .host_write_request_i  (host_write_request_i),
        .host_write_response_o (host_write_response_o),
        .bus_rw_address_o      (bus_rw_address_o),
        .bus_read_data_i       (bus_read_data_i),
        .bus_read_request_o    (bus_read_request_o),
        .bus_read_response_i   (bus_read_response_i),
        .bus_write_data_o      (bus_write_data_o),
        .bus_write_strobe_o    (bus_write_strobe_o),
        .bus_write_request_o   (bus_write_request_o),
        .bus_write_response_i  (bus_write_response_i),
        .grant_o               (grant_o),
        .timeout_o             (timeout_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct { bit rd; bit both; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; } cmd_t;
    typedef struct { bit rd; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; } bus_exp_t;
    typedef struct { int m; bit rd; logic [31:0] data; bit to; } rsp_exp_t;

    cmd_t     cq0[$];
    cmd_t     cq1[$];
    bus_exp_t exp_bus[$];
    rsp_exp_t exp_rsp[$];

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus device model: fixed latency, optional hang, no-device data, injected stray response.
    bit          dev_hang    = 1'b0;
    bit          dev_nodev   = 1'b0;
    bit          dev_inject  = 1'b0;
    int          dev_latency = 1;
    bit          d_pend      = 1'b0;
    bit          d_rd        = 1'b0;
    int          d_wait      = 0;
    logic [31:0] d_addr      = '0;

    function automatic logic [31:0] dev_rdata(input logic [31:0] a, input bit nodev);
        if (nodev) return 32'h0;
        if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
        return ~a;
    endfunction

    always @(posedge clock_i) begin
        if (reset_i) begin
            d_pend = 1'b0;
        end else if (bus_read_request_o || bus_write_request_o) begin
            d_pend = !dev_hang;
            d_rd   = bus_read_request_o;
            d_addr = bus_rw_address_o;
            d_wait = dev_latency;
        end
        #1;
        bus_read_response_i  = 1'b0;
        bus_write_response_i = 1'b0;
        bus_read_data_i      = '0;
        if (d_pend) begin
            if (d_wait <= 1) begin
                d_pend = 1'b0;
                if (d_rd) begin
                    bus_read_response_i = 1'b1;
                    bus_read_data_i     = dev_rdata(d_addr, dev_nodev);
                end else begin
                    bus_write_response_i = 1'b1;
                end
            end else begin
                d_wait--;
            end
        end
        if (dev_inject) begin
            bus_read_response_i = 1'b1;
            bus_read_data_i     = 32'h5555_AAAA;
        end
    end

    // Master drivers: hold a command until its response, then take the next one at once.
    bit          busy [NH];
    bit          flush = 1'b0;
    logic [NH-1:0] rsp_now = '0;
    cmd_t        drv_c;
    bit          drv_got;

    always @(posedge clock_i) begin
        #1;
        for (int m = 0; m < NH; m++) begin
            if (flush) busy[m] = 1'b0;
            else if (busy[m] && rsp_now[m]) busy[m] = 1'b0;
            drv_got = 1'b0;
            if (!busy[m] && !flush) begin
                if (m == 0 && cq0.size() > 0) begin drv_c = cq0.pop_front(); drv_got = 1'b1; end
                else if (m == 1 && cq1.size() > 0) begin drv_c = cq1.pop_front(); drv_got = 1'b1; end
            end
            if (drv_got) begin
                busy[m]                        = 1'b1;
                host_rw_address_i[m*32 +: 32]  = drv_c.addr;
                host_write_data_i[m*32 +: 32]  = drv_c.wdata;
                host_write_strobe_i[m*4 +: 4]  = drv_c.strb;
                host_read_request_i[m]         = drv_c.rd;
                host_write_request_i[m]        = !drv_c.rd || drv_c.both;
            end else if (!busy[m]) begin
                host_read_request_i[m]  = 1'b0;
                host_write_request_i[m] = 1'b0;
            end
        end
    end

    // Monitor: pops scoreboard entries as the DUT issues bus requests and master responses.
    int         cyc   = 0;
    int         n_rsp = 0;
    int         n_to  = 0;
    int         bus_cyc_q[$];
    int         rsp_cyc_q[$];
    logic [NH-1:0] gseq[$];
    logic [NH-1:0] prev_grant = '0;
    bus_exp_t   mb;
    rsp_exp_t   mr;
    int         midx;

    always @(negedge clock_i) begin
        cyc++;
        rsp_now = host_read_response_o | host_write_response_o;
        if (timeout_o) n_to++;
        if (bus_read_request_o || bus_write_request_o) begin
            bus_cyc_q.push_back(cyc);
            if (exp_bus.size() == 0) begin
                check("spurious_bus", {bus_read_request_o, bus_write_request_o}, 0);
            end else begin
                mb = exp_bus.pop_front();
                check("bus_rd", bus_read_request_o, mb.rd);
                check("bus_wr", bus_write_request_o, !mb.rd);
                check("bus_addr", bus_rw_address_o, mb.addr);
                if (!mb.rd) begin
                    check("bus_wdata", bus_write_data_o, mb.wdata);
                    check("bus_strb", bus_write_strobe_o, mb.strb);
                end
            end
        end
        if (rsp_now != '0) begin
            n_rsp++;
            rsp_cyc_q.push_back(cyc);
            check("rsp_onehot", $countones(rsp_now), 1);
            midx = rsp_now[1] ? 1 : 0;
            if (exp_rsp.size() == 0) begin
                check("spurious_rsp", rsp_now, 0);
            end else begin
                mr = exp_rsp.pop_front();
                check("rsp_master", midx, mr.m);
                check("rsp_is_read", host_read_response_o[midx], mr.rd);
                if (mr.rd) check("rsp_rdata", host_read_data_o[midx*32 +: 32], mr.data);
                check("rsp_timeout", timeout_o, mr.to);
            end
        end else if (timeout_o) begin
            check("timeout_alone", timeout_o, 0);
        end
        if (grant_o != '0 && prev_grant == '0) gseq.push_back(grant_o);
        prev_grant = grant_o;
    end

    task automatic issue(input int m, input bit rd, input bit both, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [31:0] rdata, input bit to, input bit expect_rsp);
        cmd_t     c;
        bus_exp_t b;
        rsp_exp_t r;
        c.rd = rd; c.both = both; c.addr = addr; c.wdata = wdata; c.strb = strb;
        b.rd = rd; b.addr = addr; b.wdata = wdata; b.strb = strb;
        r.m = m; r.rd = rd; r.data = rdata; r.to = to;
        if (m == 0) cq0.push_back(c); else cq1.push_back(c);
        exp_bus.push_back(b);
        if (expect_rsp) exp_rsp.push_back(r);
    endtask

    task automatic do_reset();
        @(negedge clock_i);
        flush       = 1'b1;
        reset_i     = 1'b1;
        dev_hang    = 1'b0;
        dev_nodev   = 1'b0;
        dev_latency = 1;
        @(negedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (n < 300 && !(exp_rsp.size() == 0 && exp_bus.size() == 0 && cq0.size() == 0 &&
                            cq1.size() == 0 && !busy[0] && !busy[1])) begin
            @(negedge clock_i);
            n++;
        end
        check({tag, "_drain"}, exp_rsp.size() + exp_bus.size(), 0);
        @(negedge clock_i);
    endtask

    initial begin
        int b0, r0, t0, g0, nr0, n;

        // Reset state
        reset_i = 1'b1;
        repeat (2) @(negedge clock_i);
        check("rst_grant", grant_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_bus_req", {bus_read_request_o, bus_write_request_o}, 0);
        check("rst_rsp", {host_read_response_o, host_write_response_o}, 0);
        reset_i = 1'b0;
        @(negedge clock_i);

        // Single read, 1-cycle device
        b0 = bus_cyc_q.size(); r0 = rsp_cyc_q.size(); g0 = gseq.size();
        issue(0, 1, 0, 32'h0000_1000, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 1);
        drain("t1");
        check("t1_bus_cycles", bus_cyc_q.size() - b0, 1);
        check("t1_latency", rsp_cyc_q[r0] - bus_cyc_q[b0], 1);
        check("t1_grant_seq", gseq[g0], 2'b01);
        check("t1_grant_end", grant_o, 0);

        // Both masters write continuously: grants alternate
        do_reset();
        g0 = gseq.size();
        issue(0, 0, 0, 32'h0000_00A0, 32'hA000_0001, 4'hF, 32'h0, 0, 1);
        issue(1, 0, 0, 32'h0000_00B0, 32'hB000_0001, 4'h3, 32'h0, 0, 1);
        issue(0, 0, 0, 32'h0000_00A0, 32'hA000_0002, 4'hF, 32'h0, 0, 1);
        issue(1, 0, 0, 32'h0000_00B0, 32'hB000_0002, 4'h3, 32'h0, 0, 1);
        drain("t2");
        check("t2_ngrants", gseq.size() - g0, 4);
        check("t2_g0", gseq[g0],     2'b01);
        check("t2_g1", gseq[g0 + 1], 2'b10);
        check("t2_g2", gseq[g0 + 2], 2'b01);
        check("t2_g3", gseq[g0 + 3], 2'b10);

        // Master 1 arrives while master 0 waits 5 cycles
        do_reset();
        dev_latency = 5;
        b0 = bus_cyc_q.size(); r0 = rsp_cyc_q.size();
        issue(0, 1, 0, 32'h0000_3000, 32'h0, 4'h0, ~32'h0000_3000, 0, 1);
        repeat (2) @(negedge clock_i);
        issue(1, 1, 0, 32'h0000_3100, 32'h0, 4'h0, ~32'h0000_3100, 0, 1);
        drain("t3");
        check("t3_bus_cycles", bus_cyc_q.size() - b0, 2);
        check("t3_wait_len", rsp_cyc_q[r0] - bus_cyc_q[b0], 5);
        check("t3_m1_issue", bus_cyc_q[b0 + 1] - rsp_cyc_q[r0], 1);

        // Bus hangs: forced read completion after TO wait cycles
        do_reset();
        dev_hang = 1'b1;
        b0 = bus_cyc_q.size(); r0 = rsp_cyc_q.size(); t0 = n_to;
        issue(0, 1, 0, 32'h0000_2000, 32'h0, 4'h0, 32'h0, 1, 1);
        drain("t4");
        check("t4_wait_len", rsp_cyc_q[r0] - bus_cyc_q[b0], TO);
        check("t4_timeout_pulses", n_to - t0, 1);
        nr0 = n_rsp;
        dev_inject = 1'b1;
        @(negedge clock_i);
        check("t4_late_rsp", host_read_response_o, 0);
        dev_inject = 1'b0;
        @(negedge clock_i);
        check("t4_late_count", n_rsp - nr0, 0);

        // Reset in the 2nd WAIT cycle aborts; master 0 wins again afterwards
        do_reset();
        dev_hang = 1'b1;
        b0 = bus_cyc_q.size(); nr0 = n_rsp;
        issue(0, 1, 0, 32'h0000_5000, 32'h0, 4'h0, 32'h0, 0, 0);
        n = 0;
        while (bus_cyc_q.size() == b0 && n < 50) begin @(negedge clock_i); n++; end
        check("t5_issued", bus_cyc_q.size() - b0, 1);
        @(negedge clock_i);
        check("t5_grant_wait", grant_o, 2'b01);
        @(negedge clock_i);
        reset_i  = 1'b1;
        flush    = 1'b1;
        dev_hang = 1'b0;
        @(negedge clock_i);
        check("t5_grant_after_rst", grant_o, 0);
        check("t5_no_rsp", n_rsp - nr0, 0);
        reset_i = 1'b0;
        flush   = 1'b0;
        g0 = gseq.size();
        issue(0, 1, 0, 32'h0000_4000, 32'h0, 4'h0, ~32'h0000_4000, 0, 1);
        issue(1, 1, 0, 32'h0000_4100, 32'h0, 4'h0, ~32'h0000_4100, 0, 1);
        drain("t5");
        check("t5_first_winner", gseq[g0], 2'b01);
        check("t5_second_winner", gseq[g0 + 1], 2'b10);

        // Unmapped addresses: no-device responses, read+write treated as read
        dev_nodev = 1'b1;
        t0 = n_to;
        issue(0, 1, 1, 32'hFFFF_0004, 32'h1234_5678, 4'hF, 32'h0, 0, 1);
        issue(1, 0, 0, 32'hFFFF_0000, 32'hCAFE_F00D, 4'h5, 32'h0, 0, 1);
        drain("t6");
        check("t6_no_timeout", n_to - t0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_compared);
        $fatal(1);
    end

endmodule
